// File: rtl/depth_histo_th_engine_pkg.sv
// Shared defaults and FSM state encoding for the depth histogram threshold engine.
package depth_histo_th_engine_pkg;

  localparam int dflt_depth_bit        = 12;
  localparam int dflt_bin_bit          = 8;
  localparam int dflt_histo_sram_d_bit = 20;
  localparam int dflt_th_num           = 4;
  localparam int dflt_frac_bit         = 8;
  localparam int dflt_dim_bit          = 11;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    SCAN,
    DONE
  } state_t;

endpackage

// File: rtl/depth_histo_th_engine_if.sv
// Frame control, depth input stream, threshold output and HISTO SRAM port bundle.
// master = frame source / SRAM macro side, slave = engine side.
interface depth_histo_th_engine_if #(
  parameter int p_depth_bit        = depth_histo_th_engine_pkg::dflt_depth_bit,
  parameter int p_bin_bit          = depth_histo_th_engine_pkg::dflt_bin_bit,
  parameter int p_histo_sram_d_bit = depth_histo_th_engine_pkg::dflt_histo_sram_d_bit,
  parameter int p_th_num           = depth_histo_th_engine_pkg::dflt_th_num,
  parameter int p_frac_bit         = depth_histo_th_engine_pkg::dflt_frac_bit,
  parameter int p_dim_bit          = depth_histo_th_engine_pkg::dflt_dim_bit
) ();

  logic [p_dim_bit-1:0]              width;
  logic [p_dim_bit-1:0]              height;
  logic                              frame_start;
  logic [p_th_num*p_frac_bit-1:0]    th_frac;
  logic                              depth_vld;
  logic                              depth_rdy;
  logic [p_depth_bit-1:0]            depth;
  logic                              out_vld;
  logic                              out_rdy;
  logic [p_th_num*p_depth_bit-1:0]   histo_th;
  logic                              sram_wen;
  logic [p_bin_bit-1:0]              sram_a;
  logic [p_histo_sram_d_bit-1:0]     sram_d;
  logic [p_histo_sram_d_bit-1:0]     sram_q;
  logic                              busy;

  modport master (
    output width, height, frame_start, th_frac, depth_vld, depth, out_rdy, sram_q,
    input  depth_rdy, out_vld, histo_th, sram_wen, sram_a, sram_d, busy
  );

  modport slave (
    input  width, height, frame_start, th_frac, depth_vld, depth, out_rdy, sram_q,
    output depth_rdy, out_vld, histo_th, sram_wen, sram_a, sram_d, busy
  );

endinterface

// File: rtl/depth_histo_th_engine_scan.sv
// Walks the per-bin count stream, accumulates the cumulative count and resolves each
// percentile threshold at the first bin reaching its target; results publish on the last bin.
module depth_histo_th_engine_scan #(
  parameter int p_depth_bit        = depth_histo_th_engine_pkg::dflt_depth_bit,
  parameter int p_bin_bit          = depth_histo_th_engine_pkg::dflt_bin_bit,
  parameter int p_histo_sram_d_bit = depth_histo_th_engine_pkg::dflt_histo_sram_d_bit,
  parameter int p_th_num           = depth_histo_th_engine_pkg::dflt_th_num,
  parameter int p_dim_bit          = depth_histo_th_engine_pkg::dflt_dim_bit
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   clr,
  input  logic                                   q_vld,
  input  logic [p_bin_bit-1:0]                   q_bin,
  input  logic [p_histo_sram_d_bit-1:0]          q,
  input  logic [p_th_num-1:0][2*p_dim_bit-1:0]   target,
  output logic [p_th_num*p_depth_bit-1:0]        th
);

  localparam int cum_bit = 2 * p_dim_bit + 1;
  localparam int shift   = p_depth_bit - p_bin_bit;

  logic [cum_bit-1:0]                      cum, cum_nxt;
  logic [p_th_num-1:0]                     found, found_nxt;
  logic [p_th_num-1:0][p_depth_bit-1:0]    th_work, th_nxt;
  logic [p_depth_bit-1:0]                  bin_th;
  logic                                    last;

  // The last bin forces any unresolved threshold, which only happens once counts saturate.
  always_comb begin
    cum_nxt   = cum + cum_bit'(q);
    bin_th    = p_depth_bit'(q_bin) << shift;
    last      = (q_bin == '1);
    found_nxt = found;
    th_nxt    = th_work;
    for (int k = 0; k < p_th_num; k++) begin
      if (!found[k] && ((cum_nxt >= cum_bit'(target[k])) || last)) begin
        found_nxt[k] = 1'b1;
        th_nxt[k]    = bin_th;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cum     <= '0;
      found   <= '0;
      th_work <= '0;
      th      <= '0;
    end else if (clr) begin
      cum   <= '0;
      found <= '0;
    end else if (q_vld) begin
      cum     <= cum_nxt;
      found   <= found_nxt;
      th_work <= th_nxt;
      if (last) th <= th_nxt;
    end
  end

endmodule

// File: rtl/depth_histo_th_engine.sv
// Builds a binned depth histogram in the external HISTO SRAM by read-modify-write, then
// scans it for run-time percentile thresholds. Best case one pixel per two cycles.
module depth_histo_th_engine
  import depth_histo_th_engine_pkg::*;
#(
  parameter int p_depth_bit        = dflt_depth_bit,
  parameter int p_bin_bit          = dflt_bin_bit,
  parameter int p_histo_sram_d_bit = dflt_histo_sram_d_bit,
  parameter int p_th_num           = dflt_th_num,
  parameter int p_frac_bit         = dflt_frac_bit,
  parameter int p_dim_bit          = dflt_dim_bit
) (
  input  logic                   i_CLK,
  input  logic                   i_RST,
  depth_histo_th_engine_if.slave bus
);

  localparam int n_bins   = 1 << p_bin_bit;
  localparam int tot_bit  = 2 * p_dim_bit;
  localparam int prod_bit = tot_bit + p_frac_bit;
  localparam logic [p_bin_bit:0] last_bin = (p_bin_bit + 1)'(n_bins - 1);
  localparam logic [p_bin_bit:0] scan_end = (p_bin_bit + 1)'(n_bins);
  localparam logic [p_histo_sram_d_bit-1:0] cnt_max = '1;

  state_t                                state;
  logic [tot_bit-1:0]                    total, total_in, pix_cnt;
  logic [p_th_num-1:0][tot_bit-1:0]      target, target_in;
  logic [prod_bit-1:0]                   prod;
  logic [p_bin_bit:0]                    sweep;
  logic                                  wr_phase;
  logic [p_bin_bit-1:0]                  bin_q, depth_bin;
  logic                                  q_vld;
  logic [p_bin_bit-1:0]                  q_bin;
  logic                                  out_vld;
  logic [p_histo_sram_d_bit-1:0]         q_inc;

  assign depth_bin     = bus.depth[p_depth_bit-1 -: p_bin_bit];
  assign q_inc         = (bus.sram_q == cnt_max) ? cnt_max : bus.sram_q + 1'b1;
  assign bus.depth_rdy = (state == ACCUM) && !wr_phase;
  assign bus.out_vld   = out_vld;
  assign bus.busy      = (state != IDLE);

  always_comb begin
    total_in  = tot_bit'(bus.width) * tot_bit'(bus.height);
    prod      = '0;
    target_in = '0;
    for (int k = 0; k < p_th_num; k++) begin
      prod         = prod_bit'(total_in) * prod_bit'(bus.th_frac[k*p_frac_bit +: p_frac_bit]);
      target_in[k] = prod[prod_bit-1:p_frac_bit];
    end
  end

  // Read address follows the live sample in the RD phase so Q lands in the WR phase.
  always_comb begin
    bus.sram_wen = 1'b1;
    bus.sram_a   = '0;
    bus.sram_d   = '0;
    case (state)
      CLEAR: begin
        bus.sram_wen = 1'b0;
        bus.sram_a   = sweep[p_bin_bit-1:0];
      end
      ACCUM: begin
        if (wr_phase) begin
          bus.sram_wen = 1'b0;
          bus.sram_a   = bin_q;
          bus.sram_d   = q_inc;
        end else begin
          bus.sram_a = depth_bin;
        end
      end
      SCAN:    bus.sram_a = sweep[p_bin_bit-1:0];
      default: ;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state    <= IDLE;
      total    <= '0;
      target   <= '0;
      pix_cnt  <= '0;
      sweep    <= '0;
      wr_phase <= 1'b0;
      bin_q    <= '0;
      q_vld    <= 1'b0;
      q_bin    <= '0;
      out_vld  <= 1'b0;
    end else begin
      q_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.frame_start) begin
            total   <= total_in;
            target  <= target_in;
            pix_cnt <= '0;
            sweep   <= '0;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          if (sweep == last_bin) begin
            sweep <= '0;
            state <= (total == '0) ? SCAN : ACCUM;
          end else begin
            sweep <= sweep + 1'b1;
          end
        end
        ACCUM: begin
          if (!wr_phase) begin
            if (bus.depth_vld) begin
              bin_q    <= depth_bin;
              wr_phase <= 1'b1;
            end
          end else begin
            wr_phase <= 1'b0;
            pix_cnt  <= pix_cnt + 1'b1;
            if (pix_cnt + 1'b1 == total) state <= SCAN;
          end
        end
        SCAN: begin
          // Q of the previous address is valid this cycle; one extra cycle drains bin N-1.
          q_vld <= (sweep != scan_end);
          q_bin <= sweep[p_bin_bit-1:0];
          if (sweep == scan_end) begin
            sweep   <= '0;
            out_vld <= 1'b1;
            state   <= DONE;
          end else begin
            sweep <= sweep + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_rdy) begin
            out_vld <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  depth_histo_th_engine_scan #(
    .p_depth_bit        (p_depth_bit),
    .p_bin_bit          (p_bin_bit),
    .p_histo_sram_d_bit (p_histo_sram_d_bit),
    .p_th_num           (p_th_num),
    .p_dim_bit          (p_dim_bit)
  ) u_scan (
    .clk    (i_CLK),
    .rst    (i_RST),
    .clr    (state == CLEAR),
    .q_vld  (q_vld),
    .q_bin  (q_bin),
    .q      (bus.sram_q),
    .target (target),
    .th     (bus.histo_th)
  );

endmodule

// File: tb/tb_depth_histo_th_engine.sv
// Directed bench for depth_histo_th_engine with behavioural HISTO SRAM models and an
// expected-threshold queue; a second instance uses a 4-bit counter width.
module tb_depth_histo_th_engine;

  localparam int db   = 12;
  localparam int bb   = 8;
  localparam int sb   = 20;
  localparam int sb6  = 4;
  localparam int tn   = 4;
  localparam int fb   = 8;
  localparam int mb   = 11;
  localparam int nb   = 1 << bb;
  localparam int th_w = tn * db;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  depth_histo_th_engine_if #(.p_depth_bit(db), .p_bin_bit(bb), .p_histo_sram_d_bit(sb),
                             .p_th_num(tn), .p_frac_bit(fb), .p_dim_bit(mb)) bus ();
  depth_histo_th_engine_if #(.p_depth_bit(db), .p_bin_bit(bb), .p_histo_sram_d_bit(sb6),
                             .p_th_num(tn), .p_frac_bit(fb), .p_dim_bit(mb)) bus6 ();

  depth_histo_th_engine #(.p_depth_bit(db), .p_bin_bit(bb), .p_histo_sram_d_bit(sb),
                          .p_th_num(tn), .p_frac_bit(fb), .p_dim_bit(mb))
    dut (.i_CLK(clk), .i_RST(rst), .bus(bus));
  depth_histo_th_engine #(.p_depth_bit(db), .p_bin_bit(bb), .p_histo_sram_d_bit(sb6),
                          .p_th_num(tn), .p_frac_bit(fb), .p_dim_bit(mb))
    dut6 (.i_CLK(clk), .i_RST(rst), .bus(bus6));

  logic [sb-1:0]  mem  [nb];
  logic [sb6-1:0] mem6 [nb];

  always @(posedge clk) begin
    if (!bus.sram_wen) mem[bus.sram_a] <= bus.sram_d;
    else               bus.sram_q      <= mem[bus.sram_a];
    if (!bus6.sram_wen) mem6[bus6.sram_a] <= bus6.sram_d;
    else                bus6.sram_q       <= mem6[bus6.sram_a];
  end

  int cyc = 0, acc = 0, rdy_cyc = 0, hs = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.depth_vld && bus.depth_rdy) acc <= acc + 1;
    if (bus.depth_rdy) rdy_cyc <= rdy_cyc + 1;
    if (bus.out_vld && bus.out_rdy) hs <= hs + 1;
  end

  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [th_w-1:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rdy"},  64'(bus.depth_rdy), 64'd0);
    check({tag, "_vld"},  64'(bus.out_vld),   64'd0);
    check({tag, "_th"},   64'(bus.histo_th),  64'd0);
    check({tag, "_wen"},  64'(bus.sram_wen),  64'd1);
    check({tag, "_a"},    64'(bus.sram_a),    64'd0);
    check({tag, "_d"},    64'(bus.sram_d),    64'd0);
    check({tag, "_busy"}, 64'(bus.busy),      64'd0);
  endtask

  task automatic start_frame(input logic [mb-1:0] w, input logic [mb-1:0] h,
                             input logic [tn*fb-1:0] frac, input logic [th_w-1:0] exp_th,
                             output int t0);
    @(negedge clk);
    bus.width       = w;
    bus.height      = h;
    bus.th_frac     = frac;
    bus.frame_start = 1'b1;
    exp_q.push_back(exp_th);
    t0 = cyc;
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  task automatic drive_pixels(input int n, input bit ramp, input bit gaps);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.depth_vld = 1'b0;
      end else begin
        bus.depth_vld = 1'b1;
        bus.depth     = ramp ? db'(i << 4) : '0;
        if (bus.depth_rdy) i++;
      end
    end
    @(negedge clk);
    bus.depth_vld = 1'b0;
    if (guard >= 20000) check("drive_timeout", 64'(i), 64'(n));
  endtask

  task automatic collect(input string tag, input int t0, input int exp_lat, input int hold);
    logic [th_w-1:0] exp_th, th0;
    int guard = 0;
    int hs0;
    bit stable = 1'b1;
    while (!bus.out_vld && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_valid"}, 64'(bus.out_vld), 64'd1);
    if (exp_lat > 0) check({tag, "_latency"}, 64'(cyc - t0), 64'(exp_lat));
    exp_th = exp_q.pop_front();
    check({tag, "_th"}, 64'(bus.histo_th), 64'(exp_th));
    th0 = bus.histo_th;
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      if (bus.out_vld !== 1'b1 || bus.histo_th !== th0) stable = 1'b0;
    end
    if (hold > 0) check({tag, "_hold"}, 64'(stable), 64'd1);
    hs0 = hs;
    bus.out_rdy = 1'b1;
    @(negedge clk);
    bus.out_rdy = 1'b0;
    check({tag, "_vld_drop"},  64'(bus.out_vld),  64'd0);
    check({tag, "_idle"},      64'(bus.busy),     64'd0);
    check({tag, "_handshake"}, 64'(hs - hs0),     64'd1);
    check({tag, "_th_kept"},   64'(bus.histo_th), 64'(exp_th));
  endtask

  initial begin
    int t0;
    int a0, r0, guard;
    logic [th_w-1:0] th_ramp, exp6, dropped;
    logic [tn*fb-1:0] frac_std, frac6;
    frac_std = {8'd255, 8'd192, 8'd128, 8'd64};
    frac6    = {8'd255, 8'd192, 8'd128, 8'd0};
    th_ramp  = {12'd4064, 12'd3056, 12'd2032, 12'd1008};
    exp6     = {12'd4080, 12'd4080, 12'd4080, 12'd0};

    bus.width = '0; bus.height = '0; bus.frame_start = 1'b0; bus.th_frac = '0;
    bus.depth_vld = 1'b0; bus.depth = '0; bus.out_rdy = 1'b0;
    bus6.width = '0; bus6.height = '0; bus6.frame_start = 1'b0; bus6.th_frac = '0;
    bus6.depth_vld = 1'b0; bus6.depth = '0; bus6.out_rdy = 1'b0;

    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Case 1: uniform 4x4 at depth 0
    bus.depth_vld = 1'b1; bus.depth = '0;
    a0 = acc;
    start_frame(11'd4, 11'd4, frac_std, '0, t0);
    collect("uniform", t0, 2 * nb + 2 + 2 * 16, 0);
    bus.depth_vld = 1'b0;
    check("uniform_accepted", 64'(acc - a0), 64'd16);
    check("uniform_bin0", 64'(mem[0]), 64'd16);

    // Case 2: 16x16 ramp, one pixel per bin
    start_frame(11'd16, 11'd16, frac_std, th_ramp, t0);
    drive_pixels(256, 1'b1, 1'b0);
    collect("ramp", t0, 2 * nb + 2 + 2 * 256, 0);
    check("ramp_bin100", 64'(mem[100]), 64'd1);

    // Case 3: ramp with random input gaps and a stalled consumer
    start_frame(11'd16, 11'd16, frac_std, th_ramp, t0);
    drive_pixels(256, 1'b1, 1'b1);
    collect("ramp_gaps", t0, 0, 10);

    // Case 4: reset mid-ACCUM, then restart with case 1
    start_frame(11'd16, 11'd16, frac_std, th_ramp, t0);
    drive_pixels(40, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    bus.depth_vld = 1'b0;
    #1;
    check_reset("rst_mid");
    dropped = exp_q.pop_front();
    @(negedge clk);
    rst = 1'b0;
    bus.depth_vld = 1'b1; bus.depth = '0;
    start_frame(11'd4, 11'd4, frac_std, '0, t0);
    collect("restart", t0, 2 * nb + 2 + 2 * 16, 0);
    bus.depth_vld = 1'b0;
    check("restart_bin0", 64'(mem[0]), 64'd16);
    check("restart_bin5_cleared", 64'(mem[5]), 64'd0);

    // Case 5: zero-width frame never accepts a pixel
    bus.depth_vld = 1'b1; bus.depth = '0;
    a0 = acc; r0 = rdy_cyc;
    start_frame(11'd0, 11'd5, frac_std, '0, t0);
    collect("w0", t0, 2 * nb + 2, 0);
    bus.depth_vld = 1'b0;
    check("w0_accepted", 64'(acc - a0), 64'd0);
    check("w0_rdy_cycles", 64'(rdy_cyc - r0), 64'd0);

    // Case 6: 4-bit counters, 8x8 at depth 0 saturates bin 0
    bus6.depth_vld = 1'b1; bus6.depth = '0;
    @(negedge clk);
    bus6.width = 11'd8; bus6.height = 11'd8; bus6.th_frac = frac6; bus6.frame_start = 1'b1;
    @(negedge clk);
    bus6.frame_start = 1'b0;
    guard = 0;
    while (!bus6.out_vld && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("sat_valid", 64'(bus6.out_vld), 64'd1);
    check("sat_th", 64'(bus6.histo_th), 64'(exp6));
    check("sat_bin0", 64'(mem6[0]), 64'd15);
    bus6.out_rdy = 1'b1;
    @(negedge clk);
    bus6.out_rdy = 1'b0;
    bus6.depth_vld = 1'b0;
    check("sat_vld_drop", 64'(bus6.out_vld), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
